// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage and other RegisterFileIF users.
package operand_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // One decoded instruction as held in the operand-fetch stage.
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1Addr;
    logic [REG_ADDR_W-1:0] rs2Addr;
    logic [REG_ADDR_W-1:0] rdAddr;
    logic                  wEnable;
  } issue_t;

  // Occupancy of the single-entry hold register.
  typedef enum logic [0:0] {
    OF_IDLE = 1'b0,
    OF_WAIT = 1'b1
  } of_state_e;

endpackage

// File: rtl/operand_fetch_ready_check.sv
// Readiness of one source operand. x0 is always ready. A register reserved
// by the instruction issued last cycle is not yet marked busy in the register
// file scoreboard, so the pending reservation is treated as busy here.
module operand_ready_check
  import operand_fetch_pkg::*;
#(
  parameter int REG_ADDR_W = operand_fetch_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic                  i_rf_ready,
  input  logic                  i_pend,
  input  logic [REG_ADDR_W-1:0] i_pend_addr,
  output logic                  o_ready
);

  logic w_is_x0;
  logic w_pend_hit;

  // Combine scoreboard state with the in-flight reservation override.
  always_comb begin
    w_is_x0    = (i_addr == '0);
    w_pend_hit = i_pend & (i_pend_addr == i_addr);
    o_ready    = w_is_x0 | (i_rf_ready & ~w_pend_hit);
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage. Holds one decoded instruction, presents its
// source addresses to the register file, waits for both operands to be ready
// and for EX to have room, then issues through a registered valid/ready port.
// The cycle after an issue it pulses the rd reservation toward the register
// file scoreboard.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN       = operand_fetch_pkg::XLEN,
  parameter int REG_ADDR_W = operand_fetch_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  // Decode side
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [XLEN-1:0]       dec_pc,
  input  logic [REG_ADDR_W-1:0] dec_rs1Addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2Addr,
  input  logic [REG_ADDR_W-1:0] dec_rdAddr,
  input  logic                  dec_wEnable,
  // Register file side
  output logic [REG_ADDR_W-1:0] rf_rs1Addr,
  output logic [REG_ADDR_W-1:0] rf_rs2Addr,
  input  logic [XLEN-1:0]       rf_rs1Data,
  input  logic [XLEN-1:0]       rf_rs2Data,
  input  logic                  rf_rs1Ready,
  input  logic                  rf_rs2Ready,
  output logic [REG_ADDR_W-1:0] rf_prevRdAddr,
  output logic                  rf_prevWEnable,
  // EX side
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1Data,
  output logic [XLEN-1:0]       ex_rs2Data,
  output logic [REG_ADDR_W-1:0] ex_rdAddr,
  output logic                  ex_wEnable
);

  of_state_e r_state;
  of_state_e w_state_nxt;
  issue_t    r_hold;
  logic      r_pend;

  logic      w_s_valid;
  logic      w_rs1_ok;
  logic      w_rs2_ok;
  logic      w_ex_free;
  logic      w_issue;
  logic      w_accept;
  logic      w_reserve;

  assign w_s_valid = (r_state == OF_WAIT);
  assign w_ex_free = ~ex_valid | ex_ready;

  // Source addresses come from the hold register and read as x0 when empty.
  assign rf_rs1Addr = w_s_valid ? r_hold.rs1Addr : '0;
  assign rf_rs2Addr = w_s_valid ? r_hold.rs2Addr : '0;

  operand_ready_check #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rs1_chk (
    .i_addr      (rf_rs1Addr),
    .i_rf_ready  (rf_rs1Ready),
    .i_pend      (r_pend),
    .i_pend_addr (rf_prevRdAddr),
    .o_ready     (w_rs1_ok)
  );

  operand_ready_check #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rs2_chk (
    .i_addr      (rf_rs2Addr),
    .i_rf_ready  (rf_rs2Ready),
    .i_pend      (r_pend),
    .i_pend_addr (rf_prevRdAddr),
    .o_ready     (w_rs2_ok)
  );

  // Hold-register occupancy: next state, issue/accept handshakes; flush wins.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    dec_ready   = 1'b0;
    if (flush) begin
      w_state_nxt = OF_IDLE;
    end else begin
      w_issue   = w_s_valid & w_rs1_ok & w_rs2_ok & w_ex_free;
      dec_ready = ~w_s_valid | w_issue;
      w_accept  = dec_valid & dec_ready;
      case (r_state)
        OF_IDLE: if (w_accept)             w_state_nxt = OF_WAIT;
        OF_WAIT: if (w_issue & ~w_accept)  w_state_nxt = OF_IDLE;
        default:                           w_state_nxt = OF_IDLE;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= OF_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Hold-register payload; only meaningful while occupied, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold.pc      <= dec_pc;
      r_hold.rs1Addr <= dec_rs1Addr;
      r_hold.rs2Addr <= dec_rs2Addr;
      r_hold.rdAddr  <= dec_rdAddr;
      r_hold.wEnable <= dec_wEnable;
    end
  end

  // EX output register: load on issue, drop valid once EX has taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1Data <= '0;
      ex_rs2Data <= '0;
      ex_rdAddr  <= '0;
      ex_wEnable <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (w_issue) begin
      ex_valid   <= 1'b1;
      ex_pc      <= r_hold.pc;
      ex_rs1Data <= rf_rs1Data;
      ex_rs2Data <= rf_rs2Data;
      ex_rdAddr  <= r_hold.rdAddr;
      ex_wEnable <= r_hold.wEnable;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // x0 is never reserved; issue is already suppressed by flush.
  assign w_reserve = w_issue & r_hold.wEnable & (r_hold.rdAddr != '0);

  // Reservation pipeline: pending flag and the rd it refers to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend        <= 1'b0;
      rf_prevRdAddr <= '0;
    end else begin
      r_pend <= w_reserve;
      if (w_issue) rf_prevRdAddr <= r_hold.rdAddr;
    end
  end

  // A flush in the cycle after issue cancels the reservation pulse.
  assign rf_prevWEnable = r_pend & ~flush;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch with a small register-file/scoreboard responder.
module tb_operand_fetch;

  localparam int XW = operand_fetch_pkg::XLEN;
  localparam int AW = operand_fetch_pkg::REG_ADDR_W;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          dec_valid;
  logic          dec_ready;
  logic [XW-1:0] dec_pc;
  logic [AW-1:0] dec_rs1Addr, dec_rs2Addr, dec_rdAddr;
  logic          dec_wEnable;
  logic [AW-1:0] rf_rs1Addr, rf_rs2Addr;
  logic [XW-1:0] rf_rs1Data, rf_rs2Data;
  logic          rf_rs1Ready, rf_rs2Ready;
  logic [AW-1:0] rf_prevRdAddr;
  logic          rf_prevWEnable;
  logic          ex_valid;
  logic          ex_ready;
  logic [XW-1:0] ex_pc, ex_rs1Data, ex_rs2Data;
  logic [AW-1:0] ex_rdAddr;
  logic          ex_wEnable;

  operand_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_rs1Addr    (dec_rs1Addr),
    .dec_rs2Addr    (dec_rs2Addr),
    .dec_rdAddr     (dec_rdAddr),
    .dec_wEnable    (dec_wEnable),
    .rf_rs1Addr     (rf_rs1Addr),
    .rf_rs2Addr     (rf_rs2Addr),
    .rf_rs1Data     (rf_rs1Data),
    .rf_rs2Data     (rf_rs2Data),
    .rf_rs1Ready    (rf_rs1Ready),
    .rf_rs2Ready    (rf_rs2Ready),
    .rf_prevRdAddr  (rf_prevRdAddr),
    .rf_prevWEnable (rf_prevWEnable),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_pc          (ex_pc),
    .ex_rs1Data     (ex_rs1Data),
    .ex_rs2Data     (ex_rs2Data),
    .ex_rdAddr      (ex_rdAddr),
    .ex_wEnable     (ex_wEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: register values, busy bits set by reservations, cleared by WB.
  logic [XW-1:0] regs [32];
  logic [31:0]   busy;
  logic          wb_req, clr_req;
  logic [AW-1:0] wb_addr;
  logic [XW-1:0] wb_val;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h1111_0000 + i;
      busy <= '0;
    end else begin
      if (clr_req) busy <= '0;
      if (rf_prevWEnable) busy[rf_prevRdAddr] <= 1'b1;
      if (wb_req) begin
        busy[wb_addr] <= 1'b0;
        regs[wb_addr] <= wb_val;
      end
    end
  end

  assign rf_rs1Data  = regs[rf_rs1Addr];
  assign rf_rs2Data  = regs[rf_rs2Addr];
  assign rf_rs1Ready = ~busy[rf_rs1Addr];
  assign rf_rs2Ready = ~busy[rf_rs2Addr];

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XW-1:0] pc;
    logic [XW-1:0] d1;
    logic [XW-1:0] d2;
    logic [AW-1:0] rd;
    logic          we;
  } exp_t;

  typedef struct {
    logic [XW-1:0] pc;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          we;
    logic [XW-1:0] d1;
    logic [XW-1:0] d2;
    logic          res;
  } vec_t;

  exp_t          exp_q[$];
  logic [AW-1:0] res_log[$];
  int            n_tests, n_fail;
  int            n_issued, last_issue_cyc, prev_issue_cyc, acc_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard side: pop and compare every EX handshake, log reservations.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rf_prevWEnable) res_log.push_back(rf_prevRdAddr);
        if (ex_valid && ex_ready) begin
          n_issued++;
          prev_issue_cyc = last_issue_cyc;
          last_issue_cyc = cyc;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue: pc %0h issued with nothing expected", ex_pc);
          end else begin
            e = exp_q.pop_front();
            if (ex_pc !== e.pc || ex_rs1Data !== e.d1 || ex_rs2Data !== e.d2 ||
                ex_rdAddr !== e.rd || ex_wEnable !== e.we) begin
              n_fail++;
              $display("FAIL issue_pc%0h: got pc=%0h d1=%0h d2=%0h rd=%0d we=%0b, expected pc=%0h d1=%0h d2=%0h rd=%0d we=%0b",
                       e.pc, ex_pc, ex_rs1Data, ex_rs2Data, ex_rdAddr, ex_wEnable,
                       e.pc, e.d1, e.d2, e.rd, e.we);
            end
          end
        end
      end
    end
  endtask

  // Offer one instruction; expectation is queued when the accept is seen.
  task automatic send(input logic [XW-1:0] pc, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [AW-1:0] rd, input logic we,
                      input logic [XW-1:0] d1, input logic [XW-1:0] d2);
    bit ok;
    ok          = 1'b0;
    dec_valid   = 1'b1;
    dec_pc      = pc;
    dec_rs1Addr = r1;
    dec_rs2Addr = r2;
    dec_rdAddr  = rd;
    dec_wEnable = we;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (dec_ready) begin
        exp_q.push_back('{pc: pc, d1: d1, d2: d2, rd: rd, we: we});
        acc_cyc = cyc;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    dec_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: pc %0h never accepted, expected accept within 40 cycles", pc);
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int k = 0; k < limit && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic writeback(input logic [AW-1:0] a, input logic [XW-1:0] v);
    wb_req = 1'b1; wb_addr = a; wb_val = v;
    @(posedge clk); #1;
    wb_req = 1'b0;
  endtask

  task automatic clear_busy();
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    res_log.delete();
  endtask

  vec_t          vecs[8];
  logic [AW-1:0] exp_res[$];
  int            n0, a_acc;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b1;
    dec_pc = '0; dec_rs1Addr = '0; dec_rs2Addr = '0; dec_rdAddr = '0; dec_wEnable = 1'b0;
    wb_req = 1'b0; wb_addr = '0; wb_val = '0; clr_req = 1'b0;
    n_tests = 0; n_fail = 0; n_issued = 0; last_issue_cyc = 0; prev_issue_cyc = 0; acc_cyc = 0;

    vecs[0] = '{32'h200, 5'd16, 5'd17, 5'd3,  1'b1, 32'h1111_0010, 32'h1111_0011, 1'b1};
    vecs[1] = '{32'h204, 5'd18, 5'd18, 5'd4,  1'b1, 32'h1111_0012, 32'h1111_0012, 1'b1};
    vecs[2] = '{32'h208, 5'd0,  5'd31, 5'd0,  1'b1, 32'h0,         32'h1111_001f, 1'b0};
    vecs[3] = '{32'h20c, 5'd25, 5'd0,  5'd9,  1'b0, 32'h1111_0019, 32'h0,         1'b0};
    vecs[4] = '{32'h210, 5'd20, 5'd21, 5'd15, 1'b1, 32'h1111_0014, 32'h1111_0015, 1'b1};
    vecs[5] = '{32'h214, 5'd31, 5'd16, 5'd1,  1'b1, 32'h1111_001f, 32'h1111_0010, 1'b1};
    vecs[6] = '{32'h218, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,         32'h0,         1'b0};
    vecs[7] = '{32'h21c, 5'd23, 5'd24, 5'd7,  1'b1, 32'h1111_0017, 32'h1111_0018, 1'b1};

    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_valid",   ex_valid, 0);
    chk("rst_dec_ready",  dec_ready, 1);
    chk("rst_prevWEn",    rf_prevWEnable, 0);
    chk("rst_prevRdAddr", rf_prevRdAddr, 0);
    chk("rst_ex_pc",      ex_pc, 0);
    chk("rst_ex_rs1Data", ex_rs1Data, 0);
    chk("rst_rf_rs1Addr", rf_rs1Addr, 0);
    rst = 1'b0;
    idle(2);

    // Independent back-to-back instructions
    res_log.delete();
    send(32'h100, 5'd0, 5'd0, 5'd1, 1'b1, 32'h0, 32'h0);
    a_acc = acc_cyc;
    send(32'h104, 5'd0, 5'd0, 5'd2, 1'b1, 32'h0, 32'h0);
    wait_drain("b2b_drain", 20);
    idle(3);
    chk("b2b_latency", prev_issue_cyc, a_acc + 2);
    chk("b2b_spacing", last_issue_cyc, prev_issue_cyc + 1);
    chk("b2b_res_count", res_log.size(), 2);
    if (res_log.size() == 2) begin
      chk("b2b_res0", res_log[0], 1);
      chk("b2b_res1", res_log[1], 2);
    end
    clear_busy();

    // Table-driven stream with EX always ready
    exp_res.delete();
    foreach (vecs[i]) begin
      send(vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we, vecs[i].d1, vecs[i].d2);
      if (vecs[i].res) exp_res.push_back(vecs[i].rd);
    end
    wait_drain("table_drain", 40);
    idle(3);
    chk("table_res_count", res_log.size(), exp_res.size());
    if (res_log.size() == exp_res.size()) begin
      foreach (exp_res[i]) chk($sformatf("table_res%0d", i), res_log[i], exp_res[i]);
    end
    clear_busy();

    // RAW: dependent instruction waits for write-back
    n0 = n_issued;
    send(32'h300, 5'd0, 5'd0, 5'd4, 1'b1, 32'h0, 32'h0);
    send(32'h304, 5'd4, 5'd0, 5'd6, 1'b1, 32'hCAFE_0004, 32'h0);
    idle(6);
    chk("raw_held", n_issued, n0 + 1);
    chk("raw_held_valid", ex_valid, 0);
    writeback(5'd4, 32'hCAFE_0004);
    wait_drain("raw_drain", 20);
    idle(3);
    chk("raw_issued", n_issued, n0 + 2);
    chk("raw_res_count", res_log.size(), 2);
    if (res_log.size() == 2) begin
      chk("raw_res0", res_log[0], 4);
      chk("raw_res1", res_log[1], 6);
    end
    clear_busy();

    // EX backpressure for three cycles
    ex_ready = 1'b0;
    send(32'h400, 5'd16, 5'd0, 5'd7, 1'b1, 32'h1111_0010, 32'h0);
    send(32'h404, 5'd17, 5'd0, 5'd8, 1'b1, 32'h1111_0011, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), ex_valid, 1);
      chk($sformatf("bp_pc%0d", k), ex_pc, 32'h400);
      chk($sformatf("bp_data%0d", k), ex_rs1Data, 32'h1111_0010);
      chk($sformatf("bp_dec_ready%0d", k), dec_ready, 0);
    end
    #1;
    chk("bp_res_count_stalled", res_log.size(), 1);
    @(posedge clk); #1;
    ex_ready = 1'b1;
    wait_drain("bp_drain", 20);
    idle(3);
    chk("bp_res_count", res_log.size(), 2);
    if (res_log.size() == 2) begin
      chk("bp_res0", res_log[0], 7);
      chk("bp_res1", res_log[1], 8);
    end
    clear_busy();

    // Flush the cycle after issuing rd=5
    n0 = n_issued;
    send(32'h500, 5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
    send(32'h504, 5'd20, 5'd0, 5'd10, 1'b1, 32'h1111_0014, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_prevWEn", rf_prevWEnable, 0);
    chk("flush_dec_ready", dec_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_s_empty", rf_rs1Addr, 0);
    chk("flush_dec_ready_after", dec_ready, 1);
    idle(4);
    chk("flush_no_issue", n_issued, n0 + 1);
    chk("flush_no_res", res_log.size(), 0);
    chk("flush_x5_ready", busy[5], 0);
    clear_busy();

    // rs1 == rs2 on a busy register, rd = 0 with write enable
    n0 = n_issued;
    send(32'h600, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0);
    send(32'h604, 5'd3, 5'd3, 5'd0, 1'b1, 32'h0BAD_0003, 32'h0BAD_0003);
    idle(5);
    chk("same_src_held", n_issued, n0 + 1);
    writeback(5'd3, 32'h0BAD_0003);
    wait_drain("same_src_drain", 20);
    idle(3);
    chk("same_src_single", n_issued, n0 + 2);
    chk("rd0_res_count", res_log.size(), 1);
    if (res_log.size() == 1) chk("rd0_res0", res_log[0], 3);
    clear_busy();

    // Asynchronous reset while an instruction waits and a reservation is pending
    n0 = n_issued;
    send(32'h700, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
    send(32'h704, 5'd9, 5'd0, 5'd11, 1'b1, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_dec_ready", dec_ready, 1);
    chk("arst_prevWEn", rf_prevWEnable, 0);
    chk("arst_prevRdAddr", rf_prevRdAddr, 0);
    chk("arst_ex_pc", ex_pc, 0);
    chk("arst_s_empty", rf_rs1Addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    chk("arst_no_res", res_log.size(), 0);
    chk("arst_no_issue", n_issued, n0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
